ex_mem_stage: RTL

Execute stage plus EX/MEM pipeline register of the 5-stage MIPS core.
- Consumes the E-side outputs of the ID/EX register.
- Performs operand selection, ALU operation, destination-register selection and branch-target computation.
- Registers the results and forwarded control bits for the MEM stage.
- Adds hold (stall) and bubble (flush) control plus an arithmetic-overflow guard on register writes.

---
 rtl/ex_mem_if.sv | 31 +++
 rtl/ex_mem_stage.sv | 108 ++++++++++
 2 files changed

// File: rtl/ex_mem_if.sv
// Execute-side inputs and EX/MEM register outputs of the MIPS pipeline.
// The stage owns the M-side; whoever sources ID/EX drives the E-side and hold/bubble controls.
interface ex_mem_if #(parameter int WIDTH = 32);
    logic             StallM, FlushM;
    logic             RegWriteE, MemtoRegE, MemWriteE, BranchE;
    logic             ALUSrcE, ALUSrc_shamtE, RegDstE;
    logic [3:0]       ALUControlE;
    logic [WIDTH-1:0] RD1E, RD2E, SignImmE, PCplus4E;
    logic [4:0]       RtE, RdE, shamtE;

    logic             RegWriteM, MemtoRegM, MemWriteM, BranchM;
    logic             ZeroM, OverflowM;
    logic [WIDTH-1:0] ALUOutM, WriteDataM, PCBranchM;
    logic [4:0]       WriteRegM;

    modport master (
        output StallM, FlushM, RegWriteE, MemtoRegE, MemWriteE, BranchE,
               ALUSrcE, ALUSrc_shamtE, RegDstE, ALUControlE,
               RD1E, RD2E, SignImmE, PCplus4E, RtE, RdE, shamtE,
        input  RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM, OverflowM,
               ALUOutM, WriteDataM, WriteRegM, PCBranchM
    );

    modport slave (
        input  StallM, FlushM, RegWriteE, MemtoRegE, MemWriteE, BranchE,
               ALUSrcE, ALUSrc_shamtE, RegDstE, ALUControlE,
               RD1E, RD2E, SignImmE, PCplus4E, RtE, RdE, shamtE,
        output RegWriteM, MemtoRegM, MemWriteM, BranchM, ZeroM, OverflowM,
               ALUOutM, WriteDataM, WriteRegM, PCBranchM
    );
endinterface

// File: rtl/ex_mem_stage.sv
// MIPS execute stage and EX/MEM pipeline register, with hold, bubble and
// a guard that suppresses register writes on signed ADD/SUB overflow.
module ex_mem_stage #(
    parameter int WIDTH = 32
) (
    input  logic     CLOCK,
    input  logic     RESET,
    ex_mem_if.slave  bus
);
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_ADDU = 4'b1010;
    localparam logic [3:0] ALU_SUBU = 4'b1011;
    localparam logic [3:0] ALU_SLTU = 4'b1100;

    typedef struct packed {
        logic             reg_write;
        logic             mem_to_reg;
        logic             mem_write;
        logic             branch;
        logic             zero;
        logic             overflow;
        logic [WIDTH-1:0] alu_out;
        logic [WIDTH-1:0] write_data;
        logic [4:0]       write_reg;
        logic [WIDTH-1:0] pc_branch;
    } mreg_t;

    logic [WIDTH-1:0] src_a, src_b, sum, diff, alu_res;
    logic [4:0]       shamt;
    logic             ovf;
    mreg_t            m_d, m_q;

    always_comb begin
        src_a   = bus.RD1E;
        src_b   = bus.ALUSrcE ? bus.SignImmE : bus.RD2E;
        shamt   = bus.ALUSrc_shamtE ? bus.shamtE : bus.RD1E[4:0];
        sum     = src_a + src_b;
        diff    = src_a - src_b;
        alu_res = '0;
        ovf     = 1'b0;
        case (bus.ALUControlE)
            ALU_AND:  alu_res = src_a & src_b;
            ALU_OR:   alu_res = src_a | src_b;
            ALU_ADD: begin
                alu_res = sum;
                ovf     = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_XOR:  alu_res = src_a ^ src_b;
            ALU_NOR:  alu_res = ~(src_a | src_b);
            ALU_SLL:  alu_res = bus.RD2E << shamt;
            ALU_SUB: begin
                alu_res = diff;
                ovf     = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_SRL:  alu_res = bus.RD2E >> shamt;
            ALU_SRA:  alu_res = $signed(bus.RD2E) >>> shamt;
            ALU_ADDU: alu_res = sum;
            ALU_SUBU: alu_res = diff;
            ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            default:  alu_res = '0;
        endcase
    end

    // Bubble beats hold; an overflowing ADD/SUB still flows down but cannot write back.
    always_comb begin
        m_d = m_q;
        if (bus.FlushM) begin
            m_d = '0;
        end else if (!bus.StallM) begin
            m_d.reg_write  = bus.RegWriteE & ~ovf;
            m_d.mem_to_reg = bus.MemtoRegE;
            m_d.mem_write  = bus.MemWriteE;
            m_d.branch     = bus.BranchE;
            m_d.zero       = (alu_res == '0);
            m_d.overflow   = ovf;
            m_d.alu_out    = alu_res;
            m_d.write_data = bus.RD2E;
            m_d.write_reg  = bus.RegDstE ? bus.RdE : bus.RtE;
            m_d.pc_branch  = bus.PCplus4E + {bus.SignImmE[WIDTH-3:0], 2'b00};
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) m_q <= '0;
        else       m_q <= m_d;
    end

    assign bus.RegWriteM  = m_q.reg_write;
    assign bus.MemtoRegM  = m_q.mem_to_reg;
    assign bus.MemWriteM  = m_q.mem_write;
    assign bus.BranchM    = m_q.branch;
    assign bus.ZeroM      = m_q.zero;
    assign bus.OverflowM  = m_q.overflow;
    assign bus.ALUOutM    = m_q.alu_out;
    assign bus.WriteDataM = m_q.write_data;
    assign bus.WriteRegM  = m_q.write_reg;
    assign bus.PCBranchM  = m_q.pc_branch;
endmodule
